// File: rtl/seq1101_arbiter_if.sv
// ============================================================================
// Module   : seq1101_arbiter_if
// Desc     : Request/grant and result bus between the serial requesters and
//            the shared 1101 detector arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq1101_arbiter_if #(
    parameter int N     = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
);
    logic [N-1:0]       req;
    logic [N*LEN_W-1:0] len;
    logic [N-1:0]       bit_in;
    logic [N-1:0]       gnt;
    logic               busy;
    logic               match;
    logic               done;
    logic [1:0]         done_id;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output req, len, bit_in,
        input  gnt, busy, match, done, done_id, match_cnt
    );

    modport slave (
        input  req, len, bit_in,
        output gnt, busy, match, done, done_id, match_cnt
    );
endinterface

`default_nettype wire

// File: rtl/seq1101_arbiter.sv
// ============================================================================
// Module   : seq1101_arbiter
// Desc     : Round-robin owner of one shared "1101" serial detector; counts
//            matches per committed frame and reports count plus owner ID.
// Macro    : SEQ_OVERLAP_EN - when defined, overlapping patterns are counted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq1101_arbiter #(
    parameter int N     = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq1101_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT  = 2'd1;
    localparam logic [1:0] c_SHIFT  = 2'd2;
    localparam logic [1:0] c_REPORT = 2'd3;

    localparam logic [1:0] c_D_START = 2'd0;
    localparam logic [1:0] c_D_ID1   = 2'd1;
    localparam logic [1:0] c_D_ID11  = 2'd2;
    localparam logic [1:0] c_D_ID110 = 2'd3;

`ifdef SEQ_OVERLAP_EN
    localparam logic [1:0] c_D_AFTER_HIT = c_D_ID1;
`else
    localparam logic [1:0] c_D_AFTER_HIT = c_D_START;
`endif

    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [1:0]       c_LAST_RST = 2'(N - 1);

    logic [1:0]       r_state,     w_state_next;
    logic [1:0]       r_owner,     w_owner_next;
    logic [1:0]       r_last,      w_last_next;
    logic [LEN_W-1:0] r_remain,    w_remain_next;
    logic [1:0]       r_det,       w_det_next;
    logic [CNT_W-1:0] r_cnt,       w_cnt_next;
    logic [1:0]       r_done_id,   w_done_id_next;
    logic [CNT_W-1:0] r_match_cnt, w_match_cnt_next;

    logic             w_bit;
    logic [LEN_W-1:0] w_len_owner;
    logic [1:0]       w_winner;
    logic             w_found;
    logic [1:0]       w_det_adv;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_match;

    // Lane selection for the current owner.
    always_comb begin
        w_bit       = 1'b0;
        w_len_owner = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == 2'(i)) begin
                w_bit       = bus.bit_in[i];
                w_len_owner = bus.len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && bus.req[i] && (i == (int'(r_last) + k) % N)) begin
                    w_found  = 1'b1;
                    w_winner = 2'(i);
                end
            end
        end
    end

    always_comb begin
        w_det_adv = c_D_START;
        w_hit     = 1'b0;
        case (r_det)
            c_D_START: w_det_adv = w_bit ? c_D_ID1  : c_D_START;
            c_D_ID1:   w_det_adv = w_bit ? c_D_ID11 : c_D_START;
            c_D_ID11:  w_det_adv = w_bit ? c_D_ID11 : c_D_ID110;
            default: begin
                if (w_bit) begin
                    w_hit     = 1'b1;
                    w_det_adv = c_D_AFTER_HIT;
                end
            end
        endcase
        w_cnt_inc = (w_hit && (r_cnt != c_CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
    end

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_last_next      = r_last;
        w_remain_next    = r_remain;
        w_det_next       = r_det;
        w_cnt_next       = r_cnt;
        w_done_id_next   = r_done_id;
        w_match_cnt_next = r_match_cnt;
        w_match          = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_next = c_GRANT;
                    w_owner_next = w_winner;
                end
            end
            c_GRANT: begin
                w_remain_next = w_len_owner;
                w_det_next    = c_D_START;
                w_cnt_next    = '0;
                if (w_len_owner != '0) begin
                    w_state_next = c_SHIFT;
                end else begin
                    w_state_next     = c_REPORT;
                    w_done_id_next   = r_owner;
                    w_match_cnt_next = '0;
                end
            end
            c_SHIFT: begin
                w_match       = w_hit;
                w_det_next    = w_det_adv;
                w_cnt_next    = w_cnt_inc;
                w_remain_next = r_remain - 1'b1;
                // Result registers load on entry so they are valid alongside done.
                if (r_remain == LEN_W'(1)) begin
                    w_state_next     = c_REPORT;
                    w_done_id_next   = r_owner;
                    w_match_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_last_next  = r_owner;
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_owner     <= '0;
            r_last      <= c_LAST_RST;
            r_remain    <= '0;
            r_det       <= c_D_START;
            r_cnt       <= '0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_last      <= w_last_next;
            r_remain    <= w_remain_next;
            r_det       <= w_det_next;
            r_cnt       <= w_cnt_next;
            r_done_id   <= w_done_id_next;
            r_match_cnt <= w_match_cnt_next;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_gnt
        assign bus.gnt[i] = ((r_state == c_GRANT) || (r_state == c_SHIFT)) && (r_owner == 2'(i));
    end

    assign bus.busy      = (r_state != c_IDLE);
    assign bus.done      = (r_state == c_REPORT);
    assign bus.match     = w_match;
    assign bus.done_id   = r_done_id;
    assign bus.match_cnt = r_match_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seq1101_arbiter.sv
// ============================================================================
// Module   : tb_seq1101_arbiter
// Desc     : Self-checking bench for seq1101_arbiter against a frame-level
//            pattern-count and round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq1101_arbiter;

    localparam int c_N   = 4;
    localparam int c_LW  = 4;
    localparam int c_CW  = 4;
    localparam int c_CW2 = 2;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   m_last = c_N - 1;

    seq1101_arbiter_if #(.N(c_N), .LEN_W(c_LW), .CNT_W(c_CW))  bus ();
    seq1101_arbiter_if #(.N(c_N), .LEN_W(c_LW), .CNT_W(c_CW2)) bus2 ();

    seq1101_arbiter #(.N(c_N), .LEN_W(c_LW), .CNT_W(c_CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq1101_arbiter #(.N(c_N), .LEN_W(c_LW), .CNT_W(c_CW2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-bit match flags: a match ends at bit j when bits j-3..j read 1,1,0,1
    // in time order and (non-overlapping) share no bit with an earlier match.
    function automatic logic [15:0] exp_flags(input logic [15:0] b, input int len);
        logic [15:0] f;
        int          first_free;
        f          = '0;
        first_free = 0;
        for (int j = 3; j < len; j++) begin
            if (b[j-3] && b[j-2] && !b[j-1] && b[j] && (j - 3 >= first_free)) begin
                f[j] = 1'b1;
`ifdef SEQ_OVERLAP_EN
                first_free = 0;
`else
                first_free = j + 1;
`endif
            end
        end
        return f;
    endfunction

    function automatic int sat_count(input logic [15:0] f, input int cw);
        int c;
        int mx;
        c  = $countones(f);
        mx = (1 << cw) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic int arb(input logic [3:0] r, input int last);
        for (int k = 1; k <= c_N; k++) begin
            if (r[(last + k) % c_N]) return (last + k) % c_N;
        end
        return -1;
    endfunction

    // Called in an IDLE cycle with req/len already driven; ends in the
    // following IDLE cycle with nreq/nlen driven.
    task automatic do_frame(input logic [15:0] bits, input logic [3:0] nreq, input logic [15:0] nlen);
        int          o;
        int          l;
        logic [15:0] f;
        int          cnt;
        o   = arb(bus.req, m_last);
        l   = int'(bus.len[o*c_LW +: c_LW]);
        f   = exp_flags(bits, l);
        cnt = sat_count(f, c_CW);
        @(negedge clk); #1;
        check("gnt_grant", 32'(bus.gnt), 32'(1 << o));
        check("busy_grant", 32'(bus.busy), 32'd1);
        bus.req = 4'($urandom);
        for (int j = 0; j < l; j++) begin
            @(negedge clk);
            bus.bit_in    = 4'($urandom);
            bus.bit_in[o] = bits[j];
            bus.len       = 16'($urandom);
            bus.req       = 4'($urandom);
            #1;
            check("match", 32'(bus.match), 32'(f[j]));
            check("gnt_shift", 32'(bus.gnt), 32'(1 << o));
            check("done_early", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        bus.req = nreq;
        bus.len = nlen;
        #1;
        check("done", 32'(bus.done), 32'd1);
        check("done_id", 32'(bus.done_id), 32'(o));
        check("match_cnt", 32'(bus.match_cnt), 32'(cnt));
        check("gnt_report", 32'(bus.gnt), 32'd0);
        check("match_report", 32'(bus.match), 32'd0);
        m_last = o;
        @(negedge clk); #1;
        check("done_idle", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("cnt_hold", 32'(bus.match_cnt), 32'(cnt));
    endtask

    initial begin
        logic [15:0] sat_bits;
        logic [15:0] sat_f;

        reset       = 1'b0;
        bus.req     = 4'b0001;
        bus.len     = 16'h0004;
        bus.bit_in  = '0;
        bus2.req    = '0;
        bus2.len    = '0;
        bus2.bit_in = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_match", 32'(bus.match), 32'd0);
        check("rst_done_id", 32'(bus.done_id), 32'd0);
        check("rst_cnt", 32'(bus.match_cnt), 32'd0);
        reset = 1'b1;

        // Bits are listed LSB-first in time order.
        do_frame(16'h000B, 4'b0100, 16'h0700);          // req0: 1101
        do_frame(16'h005B, 4'b0010, 16'h0000);          // req2: 1101101
        do_frame(16'h0000, 4'b1000, 16'h5000);          // req1: len 0
        do_frame(16'($urandom), 4'b1111, 16'h1111);     // req3: random bits
        for (int i = 0; i < 5; i++) begin
            do_frame(16'($urandom), 4'b1111, 16'h1111); // expect 0,1,2,3,0
        end
        for (int i = 0; i < 10; i++) begin
            do_frame(16'($urandom), 4'($urandom_range(1, 15)), 16'($urandom));
        end
        do_frame(16'($urandom), 4'b0001, 16'h000F);

        // Abort a committed frame with reset while shifting.
        @(negedge clk); #1;
        check("gnt_pre_abort", 32'(bus.gnt), 32'd1);
        bus.req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            bus.bit_in = 4'($urandom);
        end
        reset = 1'b0;
        #1;
        check("abort_gnt", 32'(bus.gnt), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_cnt", 32'(bus.match_cnt), 32'd0);
        check("abort_done_id", 32'(bus.done_id), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        m_last = c_N - 1;
        @(negedge clk); #1;
        check("post_abort_busy", 32'(bus.busy), 32'd0);
        check("post_abort_done", 32'(bus.done), 32'd0);
        bus.req = 4'b1111;
        bus.len = 16'h3333;
        do_frame(16'($urandom), 4'b0000, 16'h0000);

        // Saturating 2-bit counter on the second instance.
        sat_bits  = 16'h36DB;
        sat_f     = exp_flags(sat_bits, 15);
        bus2.req  = 4'b0001;
        bus2.len  = 16'h000F;
        @(negedge clk); #1;
        check("sat_gnt", 32'(bus2.gnt), 32'd1);
        bus2.req = 4'b0000;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            bus2.bit_in = {3'b000, sat_bits[j]};
            #1;
            check("sat_match", 32'(bus2.match), 32'(sat_f[j]));
        end
        @(negedge clk); #1;
        check("sat_done", 32'(bus2.done), 32'd1);
        check("sat_cnt", 32'(bus2.match_cnt), 32'(sat_count(sat_f, c_CW2)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
